parity_arb_ctrl: RTL and testbench

Round-robin arbiter and sequencer that shares one parity-generation unit between two requesters. Each requester presents a data byte plus an even/odd select over a valid/ready handshake. The granted byte passes through the shared parity unit into a single-entry output register as a 9-bit parity-extended word tagged with the requester ID. The block sits between the byte producers and the serial framer/link stage that consumes parity-protected words.

---
 rtl/parity_arb_pkg.sv | 24 ++
 rtl/parity_arb_ctrl_parity_unit.sv | 15 +
 rtl/parity_arb_ctrl.sv | 154 +++++++++++++++
 tb/tb_parity_arb_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_arb_pkg.sv
// Shared constants and types for parity_arb_ctrl; optional statistics are enabled by PARITY_ARB_STATS_EN.
// Holds no logic, so it adds no latency and has no backpressure behaviour.
package parity_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Round-robin preference: the requester that did not win last time.
  function automatic logic rr_other(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/parity_arb_ctrl_parity_unit.sv
// Shared parity generator: combinational, zero latency, never stalls.
// Even mode makes the total ones count even; odd mode makes it odd.
module parity_unit
  import parity_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd,
  output logic              parity_bit
);

  assign parity_bit = (odd == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/parity_arb_ctrl.sv
// Two-way round-robin arbiter feeding one parity unit into a single-entry output register (1-cycle latency).
// Requesters see ready only when the register is empty or draining; PARITY_ARB_STATS_EN adds saturating accept counters.
module parity_arb_ctrl
  import parity_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef PARITY_ARB_STATS_EN
  ,
  parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_odd,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_odd,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W:0]   out_word,
  output logic              out_id,
  input  logic              out_ready
`ifdef PARITY_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_cnt0,
  output logic [CNT_W-1:0]  stat_cnt1
`endif
);

  typedef struct packed {
    logic            id;
    logic [DATA_W:0] word;
  } out_reg_t;

  out_state_e state_q, state_d;
  out_reg_t   out_q, out_d;
  logic       last_q, last_d;

  logic              load;
  logic              grant_vld;
  logic              grant_id;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_odd;
  logic              par_bit;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = last_q;
    unique case ({req1_valid, req0_valid})
      2'b01: begin
        grant_vld = 1'b1;
        grant_id  = REQ0;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = REQ1;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = rr_other(last_q);
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = last_q;
      end
    endcase
  end

  // Reset gates accept so nothing is taken in the cycle the register is being cleared.
  assign load       = (state_q == OUT_EMPTY) || out_ready;
  assign accept     = !rst && load && grant_vld;
  assign req0_ready = accept && (grant_id == REQ0);
  assign req1_ready = accept && (grant_id == REQ1);

  assign sel_data = (grant_id == REQ1) ? req1_data : req0_data;
  assign sel_odd  = (grant_id == REQ1) ? req1_odd  : req0_odd;

  parity_unit #(
    .DATA_W (DATA_W)
  ) u_parity (
    .data       (sel_data),
    .odd        (sel_odd),
    .parity_bit (par_bit)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    last_d  = last_q;
    if (accept) begin
      out_d.word = {par_bit, sel_data};
      out_d.id   = grant_id;
      last_d     = grant_id;
    end
    unique case (state_q)
      OUT_EMPTY: begin
        if (accept) state_d = OUT_FULL;
      end
      OUT_FULL: begin
        if (out_ready && !accept) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      out_q   <= '0;
      last_q  <= REQ1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_word  = out_q.word;
  assign out_id    = out_q.id;

`ifdef PARITY_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (req1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`endif

  a_one_grant: assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule

// File: tb/tb_parity_arb_ctrl.sv
// Scoreboard bench for parity_arb_ctrl: directed vectors push expected words, a monitor pops on each handshake.
// Covers reset, single requests, contention, backpressure, mid-run reset, idle and (with PARITY_ARB_STATS_EN) counters.
module tb_parity_arb_ctrl;

  localparam int DATA_W = 8;
`ifdef PARITY_ARB_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_odd, req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_odd, req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic              out_valid, out_id, out_ready;
  logic [DATA_W:0]   out_word;
`ifdef PARITY_ARB_STATS_EN
  logic [CNT_W-1:0]  stat_cnt0, stat_cnt1;
`endif

  always #5 clk = ~clk;

  parity_arb_ctrl #(
    .DATA_W (DATA_W)
`ifdef PARITY_ARB_STATS_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_odd   (req0_odd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_odd   (req1_odd),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_id     (out_id),
    .out_ready  (out_ready)
`ifdef PARITY_ARB_STATS_EN
    ,
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1)
`endif
  );

  typedef struct packed {
    logic            id;
    logic [DATA_W:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [DATA_W-1:0] d0, input logic o0,
                       input logic v1, input logic [DATA_W-1:0] d1, input logic o1,
                       input logic ordy);
    req0_valid = v0; req0_data = d0; req0_odd = o0;
    req1_valid = v1; req1_data = d1; req1_odd = o1;
    out_ready  = ordy;
  endtask

  task automatic push(input logic id, input logic [DATA_W:0] w);
    exp_q.push_back({id, w});
  endtask

  task automatic chk_ready(input string name, input logic r0, input logic r1);
    chk({name, "_ready0"}, req0_ready, r0);
    chk({name, "_ready1"}, req1_ready, r1);
  endtask

  // Monitor: every handshake outside reset must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got word %0h id %0h with nothing expected", out_word, out_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_word", out_word, mon_e.word);
        chk("out_id", out_id, mon_e.id);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    next();

    // Reset state; a valid request must not be accepted while reset is high.
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", out_word, 9'h000);
    chk("rst_out_id", out_id, 1'b0);
    chk_ready("rst", 1'b0, 1'b0);
    next();

    // Contention after reset: strict alternation starting with requester 0.
    rst = 1'b0;
    drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(1'b0, 9'h101);
      else            push(1'b1, 9'h003);
      @(negedge clk);
      chk_ready("contend", (k % 2 == 0), (k % 2 == 1));
      next();
    end

    // Backpressure: held word stable and no readies for three cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_word", out_word, 9'h003);
      chk("bp_id", out_id, 1'b1);
      chk_ready("bp", 1'b0, 1'b0);
      next();
    end
    out_ready = 1'b1;
    push(1'b0, 9'h101);
    @(negedge clk);
    chk_ready("bp_release", 1'b1, 1'b0);
    next();
    out_ready = 1'b0;
    @(negedge clk);
    chk("nogap_valid", out_valid, 1'b1);
    chk("nogap_word", out_word, 9'h101);
    chk("nogap_id", out_id, 1'b0);
    next();

    // Reset while full: the held word is dropped and nothing is accepted.
    rst = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_ready("midrst", 1'b0, 1'b0);
    next();
    rst = 1'b0;
    push(1'b0, 9'h101);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk_ready("midrst_first", 1'b1, 1'b0);
    next();
    push(1'b1, 9'h003);
    @(negedge clk);
    chk_ready("midrst_second", 1'b0, 1'b1);
    next();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    next();

    // Single requests, even then odd parity.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    push(1'b0, 9'h0A5);
    @(negedge clk);
    chk_ready("single_even", 1'b1, 1'b0);
    next();
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    push(1'b0, 9'h1A5);
    @(negedge clk);
    chk_ready("single_odd", 1'b1, 1'b0);
    next();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_odd_valid", out_valid, 1'b1);
    next();

    // Idle: register drains and stays empty.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_valid", out_valid, 1'b0);
      chk_ready("idle", 1'b0, 1'b0);
      next();
    end

    // Last winner was requester 0, so requester 1 wins this contention.
    drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1);
    push(1'b1, 9'h003);
    @(negedge clk);
    chk_ready("last_kept", 1'b0, 1'b1);
    next();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    next();

`ifdef PARITY_ARB_STATS_EN
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("stat0_rst", stat_cnt0, 4'h0);
    chk("stat1_rst", stat_cnt1, 4'h0);
    next();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      push(1'b1, 9'h003);
      @(negedge clk);
      chk_ready("stats_req1", 1'b0, 1'b1);
      next();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    next();
    @(negedge clk);
    chk("stat1_sat", stat_cnt1, 4'hF);
    chk("stat0_zero", stat_cnt0, 4'h0);
    next();
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
